// File: rtl/axis_i2s2_gain.sv
// Stereo AXI-Stream gain stage: per-channel ramped gain, soft mute, saturation with sticky clip flags.
// Latency 2 cycles from last input handshake to output valid; input is refused while output is held.
module axis_i2s2_gain #(
  parameter int GAIN_W    = 16,
  parameter int RAMP_STEP = 'h0400
) (
  input  logic              axis_clk,
  input  logic              axis_resetn,
  input  logic [31:0]       s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  input  logic              s_axis_last,
  output logic [31:0]       m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last,
  input  logic [GAIN_W-1:0] gain_l,
  input  logic [GAIN_W-1:0] gain_r,
  input  logic              mute,
  output logic              clip_l,
  output logic              clip_r,
  input  logic              clip_clr
);

  localparam int PW = 24 + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);
  localparam logic signed [PW-1:0] MAXV = PW'(8388607);
  localparam logic signed [PW-1:0] MINV = -PW'(8388608);

  typedef enum logic [2:0] {RX_L, RX_R, CALC, TX_L, TX_R} state_t;

  state_t            r_state, w_nxt;
  logic              r_s_rdy, r_m_vld, r_m_last;
  logic [31:0]       r_m_dat;
  logic [23:0]       r_in_l, r_in_r, r_hold_r;
  logic [GAIN_W-1:0] r_cur_l, r_cur_r;
  logic              r_clip_l, r_clip_r;
  logic              w_hs_in, w_unused;

  assign w_hs_in  = s_axis_valid & r_s_rdy;
  assign w_unused = ^s_axis_data[31:24];

  assign s_axis_ready = r_s_rdy;
  assign m_axis_valid = r_m_vld;
  assign m_axis_last  = r_m_last;
  assign m_axis_data  = r_m_dat;
  assign clip_l       = r_clip_l;
  assign clip_r       = r_clip_r;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      RX_L: if (w_hs_in && !s_axis_last) w_nxt = RX_R;
      RX_R: if (w_hs_in && s_axis_last) w_nxt = CALC;
      CALC: w_nxt = TX_L;
      TX_L: if (m_axis_ready) w_nxt = TX_R;
      TX_R: if (m_axis_ready) w_nxt = RX_L;
      default: w_nxt = RX_L;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state  <= RX_L;
      r_s_rdy  <= 1'b0;
      r_m_vld  <= 1'b0;
      r_m_last <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_s_rdy  <= (w_nxt == RX_L) || (w_nxt == RX_R);
      r_m_vld  <= (w_nxt == TX_L) || (w_nxt == TX_R);
      r_m_last <= (w_nxt == TX_R);
    end
  end

  // Products use the gain applied before this packet's ramp update.
  logic signed [PW-1:0] w_p_l, w_p_r, w_s_l, w_s_r;
  logic                 w_hi_l, w_lo_l, w_hi_r, w_lo_r;
  logic [23:0]          w_o_l, w_o_r;

  assign w_p_l = $signed({{(GAIN_W+1){r_in_l[23]}}, r_in_l}) * $signed({{(PW-GAIN_W){1'b0}}, r_cur_l});
  assign w_p_r = $signed({{(GAIN_W+1){r_in_r[23]}}, r_in_r}) * $signed({{(PW-GAIN_W){1'b0}}, r_cur_r});
  assign w_s_l = w_p_l >>> (GAIN_W - 2);
  assign w_s_r = w_p_r >>> (GAIN_W - 2);
  assign w_hi_l = w_s_l > MAXV;
  assign w_lo_l = w_s_l < MINV;
  assign w_hi_r = w_s_r > MAXV;
  assign w_lo_r = w_s_r < MINV;
  assign w_o_l = w_hi_l ? 24'h7FFFFF : (w_lo_l ? 24'h800000 : w_s_l[23:0]);
  assign w_o_r = w_hi_r ? 24'h7FFFFF : (w_lo_r ? 24'h800000 : w_s_r[23:0]);

  function automatic logic [GAIN_W-1:0] ramp(input logic [GAIN_W-1:0] cur,
                                             input logic [GAIN_W-1:0] tgt);
    logic [GAIN_W-1:0] res;
    if (tgt >= cur) res = ((tgt - cur) <= STEP) ? tgt : cur + STEP;
    else            res = ((cur - tgt) <= STEP) ? tgt : cur - STEP;
    return res;
  endfunction

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_in_l   <= '0;
      r_in_r   <= '0;
      r_hold_r <= '0;
      r_m_dat  <= '0;
      r_cur_l  <= '0;
      r_cur_r  <= '0;
    end else begin
      if (r_state == RX_L && w_hs_in && !s_axis_last) r_in_l <= s_axis_data[23:0];
      if (r_state == RX_R && w_hs_in) begin
        if (s_axis_last) r_in_r <= s_axis_data[23:0];
        else             r_in_l <= s_axis_data[23:0];
      end
      if (r_state == CALC) begin
        r_m_dat  <= {8'h00, w_o_l};
        r_hold_r <= w_o_r;
        r_cur_l  <= ramp(r_cur_l, mute ? '0 : gain_l);
        r_cur_r  <= ramp(r_cur_r, mute ? '0 : gain_r);
      end
      if (r_state == TX_L && m_axis_ready) r_m_dat <= {8'h00, r_hold_r};
    end
  end

  // A saturation event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_clip_l <= 1'b0;
      r_clip_r <= 1'b0;
    end else begin
      if (r_state == CALC && (w_hi_l || w_lo_l)) r_clip_l <= 1'b1;
      else if (clip_clr)                         r_clip_l <= 1'b0;
      if (r_state == CALC && (w_hi_r || w_lo_r)) r_clip_r <= 1'b1;
      else if (clip_clr)                         r_clip_r <= 1'b0;
    end
  end

endmodule

// File: doc/axis_i2s2_gain.md
Name: axis_i2s2_gain

Overview:
- AXI-Stream stereo gain stage between the I2S2 controller's RX master (upstream) and its TX slave (downstream).
- Accepts 2-word packets (left word, then right word with last=1). Applies a per-channel unsigned gain with a per-packet ramp and soft mute, saturates the result, and emits a 2-word packet in the same format.
- Removes zipper noise on gain changes and clips cleanly instead of wrapping.

Parameters:
- GAIN_W, 16, gain width; unsigned fixed point Q2.(GAIN_W-2); unity = 2^(GAIN_W-2) (0x4000).
- RAMP_STEP, 16'h0400, maximum change of the applied gain per packet, per channel.

Ports:
- axis_clk  in  1  clock, approx 22.591 MHz.
- axis_resetn  in  1  reset; asynchronous assert, active-low.
- s_axis_data  in  32  input word; [23:0] is a signed sample; [31:24] is ignored.
- s_axis_valid  in  1  input valid.
- s_axis_ready  out  1  input ready.
- s_axis_last  in  1  marks the right-channel word.
- m_axis_data  out  32  output word; [31:24]=0; [23:0] is the signed sample.
- m_axis_valid  out  1  output valid.
- m_axis_ready  in  1  output ready.
- m_axis_last  out  1  high on the right word.
- gain_l  in  GAIN_W  left target gain.
- gain_r  in  GAIN_W  right target gain.
- mute  in  1  forces both targets to 0 (ramped, not instant).
- clip_l  out  1  sticky: left saturation occurred.
- clip_r  out  1  sticky: right saturation occurred.
- clip_clr  in  1  synchronous clear of clip_l and clip_r.

Behaviour:
- Reset (axis_resetn=0, asynchronous) forces:
  - state=RX_L; s_axis_ready=0; m_axis_valid=0; m_axis_last=0; m_axis_data=0.
  - clip_l=0, clip_r=0; applied gains cur_l=0, cur_r=0 (output fades in after reset).
- Reset mid-packet aborts immediately; partial input data is discarded.
- s_axis_ready=1 only in states RX_L and RX_R. The block never accepts input while holding output.
- FSM:
  - RX_L, handshake with last=0: store L, go to RX_R.
  - RX_L, handshake with last=1: discard the word (resync), stay in RX_L.
  - RX_R, handshake with last=1: store R, go to CALC.
  - RX_R, handshake with last=0: overwrite L, stay in RX_R.
  - CALC (1 cycle): compute both results into output registers, update the ramps, go to TX_L.
  - TX_L: m_axis_valid=1, m_axis_last=0, data=L result; on m_axis_ready go to TX_R.
  - TX_R: m_axis_valid=1, m_axis_last=1, data=R result; on m_axis_ready go to RX_L.
- Output data, valid and last are registered and held stable while valid=1 and ready=0.
- Latency: last input handshake in cycle N → m_axis_valid=1 in cycle N+2. Minimum packet period is 5 cycles, far below the 512-cycle I2S frame.
- Arithmetic, per channel:
  - p = signed(sample[23:0]) × zero-extended cur gain → 41-bit signed product.
  - r = p >>> (GAIN_W-2), arithmetic shift (truncation toward −inf).
  - If r > 8388607, output 0x7FFFFF and set clip. If r < −8388608, output 0x800000 and set clip.
  - Otherwise output r[23:0].
- Ramp, in CALC, after the product is formed with the old cur:
  - target = mute ? 0 : gain_x.
  - If |target−cur| ≤ RAMP_STEP, then cur=target; else cur moves by RAMP_STEP toward target.
  - gain_x and mute are sampled only in CALC.
- Clip flags:
  - Set in CALC on saturation and stay sticky.
  - clip_clr clears them. If clear and set occur in the same cycle, set wins.

Test Plan:
- Reset then 17 packets, gain_l=gain_r=0x4000, L=0x000100, R=0xFFFF00:
  - Packet 1 outputs 0x000000 / 0x000000.
  - Packet 2 uses gain 0x0400: outputs 0x000010 / 0xFFFFF0.
  - Packet 17 outputs 0x000100 / 0xFFFF00 exactly.
  - All outputs have [31:24]=0.
- Settled gain 0x8000, L=0x500000, R=0xA00000:
  - Outputs 0x7FFFFF / 0x800000; clip_l=clip_r=1.
  - Pulse clip_clr → both flags 0.
  - Next packet L=0x100000 → 0x200000, no clip.
- Backpressure: hold m_axis_ready=0 for 10 cycles in TX_L:
  - m_axis_data, m_axis_valid and m_axis_last stay constant.
  - s_axis_ready stays 0.
  - Release → L, then R with last=1, then s_axis_ready=1.
- Framing errors:
  - Lone word with last=1 in RX_L → no output.
  - Words 0x000001 (last=0), 0x000002 (last=0), 0x000003 (last=1) at unity gain → output 0x000002 / 0x000003.
- Mute at unity:
  - mute=1 → outputs step down over 16 packets to 0.
  - mute=0 → outputs ramp back to the input value over 16 packets.
- Reset asserted while in TX_R with valid=1:
  - m_axis_valid and m_axis_last go to 0 asynchronously.
  - After release, the block is in RX_L with cur gains at 0.
